// File: rtl/fft_frame_loader_pkg.sv
// Constants shared by the FP4 FFT sample memory, its write-side loader and the FFT core,
// plus the loader's FSM state encoding.
package fft_frame_loader_pkg;

    localparam int N_POINTS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 8;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample stream, memory write port and core handshake seen by the frame loader.
// slave = loader side, master = environment (source, memory, FFT core).
interface fft_frame_loader_if;
    import fft_frame_loader_pkg::*;

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              wr_en_1;
    logic [ADDR_W-1:0] wr_addr_1;
    logic [DATA_W-1:0] wr_data_1;
    logic              bank_sel;
    logic              proc_start;
    logic              proc_done;
    logic [15:0]       frame_cnt;

    modport slave (
        input  s_valid, s_data, proc_done,
        output s_ready, wr_en_1, wr_addr_1, wr_data_1, bank_sel, proc_start, frame_cnt
    );

    modport master (
        output s_valid, s_data, proc_done,
        input  s_ready, wr_en_1, wr_addr_1, wr_data_1, bank_sel, proc_start, frame_cnt
    );

endinterface

// File: rtl/fft_frame_loader_bit_reverse.sv
// Purely combinational bit reversal of a W-bit address; also used by the FFT core's
// address generator.
module fft_frame_loader_bit_reverse
    import fft_frame_loader_pkg::*;
#(
    parameter int W = ADDR_W
) (
    input  logic [W-1:0] in_addr,
    output logic [W-1:0] out_addr
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign out_addr[gi] = in_addr[W-1-gi];
        end
    endgenerate

endmodule

// File: rtl/fft_frame_loader.sv
// Write-side controller of the ping-pong FFT sample memory: stores one frame into the
// filling bank, then swaps banks and starts the core once the core is idle.
module fft_frame_loader
    import fft_frame_loader_pkg::*;
#(
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    fft_frame_loader_if.slave   bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              bank_sel_q, bank_sel_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              proc_start_q, proc_start_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic              ready;
    logic              xfer;
    logic              core_idle;
    logic [ADDR_W-1:0] idx_rev;

    fft_frame_loader_bit_reverse #(
        .W (ADDR_W)
    ) u_bit_reverse (
        .in_addr  (idx_q),
        .out_addr (idx_rev)
    );

    // rst gates ready so the source sees no acceptance while reset is held.
    assign ready     = rst && (state_q == FILL);
    assign xfer      = bus.s_valid && ready;
    assign core_idle = !busy_q || bus.proc_done;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        busy_d       = busy_q && !bus.proc_done;
        bank_sel_d   = bank_sel_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        proc_start_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            FILL: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = BIT_REVERSE ? idx_rev : idx_q;
                    wr_data_d = bus.s_data;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == ADDR_W'(N_POINTS - 1)) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                // A swap re-arms busy even if proc_done arrives on the same edge.
                if (core_idle) begin
                    state_d      = FILL;
                    bank_sel_d   = !bank_sel_q;
                    proc_start_d = 1'b1;
                    busy_d       = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FILL;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            bank_sel_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            proc_start_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            bank_sel_q   <= bank_sel_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            proc_start_q <= proc_start_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign bus.s_ready    = ready;
    assign bus.wr_en_1    = wr_en_q;
    assign bus.wr_addr_1  = wr_addr_q;
    assign bus.wr_data_1  = wr_data_q;
    assign bus.bank_sel   = bank_sel_q;
    assign bus.proc_start = proc_start_q;
    assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: a bit-reversed and a natural-order instance share one stimulus
// stream and are compared every cycle against a frame-occupancy reference model.
module tb_fft_frame_loader;
    import fft_frame_loader_pkg::*;

    logic clk;
    logic rst;
    logic s_valid;
    logic [7:0] s_data;
    logic proc_done;

    int checks = 0;
    int errors = 0;

    fft_frame_loader_if if_rev ();
    fft_frame_loader_if if_nat ();

    assign if_rev.s_valid   = s_valid;
    assign if_rev.s_data    = s_data;
    assign if_rev.proc_done = proc_done;
    assign if_nat.s_valid   = s_valid;
    assign if_nat.s_data    = s_data;
    assign if_nat.proc_done = proc_done;

    fft_frame_loader #(.BIT_REVERSE(1'b1)) u_rev (.clk(clk), .rst(rst), .bus(if_rev));
    fft_frame_loader #(.BIT_REVERSE(1'b0)) u_nat (.clk(clk), .rst(rst), .bus(if_nat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: frame occupancy, core busy flag, bank and expected write port.
    int          m_cnt;
    bit          m_busy;
    bit          m_bank;
    bit          m_start;
    logic [15:0] m_frames;
    bit          m_wr_en;
    logic [4:0]  m_addr_rev;
    logic [4:0]  m_addr_nat;
    logic [7:0]  m_data;

    function automatic logic [4:0] ref_bitrev(input int x);
        int r = 0;
        for (int i = 0; i < ADDR_W; i++) r = r * 2 + ((x >> i) & 1);
        return 5'(r);
    endfunction

    function automatic void model_reset();
        m_cnt      = 0;
        m_busy     = 0;
        m_bank     = 0;
        m_start    = 0;
        m_frames   = '0;
        m_wr_en    = 0;
        m_addr_rev = '0;
        m_addr_nat = '0;
        m_data     = '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string nm, input logic rdy, input logic en,
                             input logic [4:0] a, input logic [7:0] dt, input logic bk,
                             input logic st, input logic [15:0] fc, input logic [4:0] exp_a);
        chk({nm, "_s_ready"},    32'(rdy), 32'(rst && (m_cnt < N_POINTS)));
        chk({nm, "_wr_en"},      32'(en),  32'(m_wr_en));
        chk({nm, "_wr_addr"},    32'(a),   32'(exp_a));
        chk({nm, "_wr_data"},    32'(dt),  32'(m_data));
        chk({nm, "_bank_sel"},   32'(bk),  32'(m_bank));
        chk({nm, "_proc_start"}, 32'(st),  32'(m_start));
        chk({nm, "_frame_cnt"},  32'(fc),  32'(m_frames));
    endtask

    // One cycle: check outputs at this negedge, drive new inputs, advance the model.
    task automatic step(input bit v, input logic [7:0] d, input bit done, input bit r);
        bit acc;
        bit full_now;
        check_dut("rev", if_rev.s_ready, if_rev.wr_en_1, if_rev.wr_addr_1, if_rev.wr_data_1,
                  if_rev.bank_sel, if_rev.proc_start, if_rev.frame_cnt, m_addr_rev);
        check_dut("nat", if_nat.s_ready, if_nat.wr_en_1, if_nat.wr_addr_1, if_nat.wr_data_1,
                  if_nat.bank_sel, if_nat.proc_start, if_nat.frame_cnt, m_addr_nat);
        s_valid   = v;
        s_data    = d;
        proc_done = done;
        rst       = r;
        if (!r) begin
            model_reset();
        end else begin
            full_now = (m_cnt == N_POINTS);
            acc      = v && (m_cnt < N_POINTS);
            m_start  = 0;
            m_wr_en  = acc;
            if (acc) begin
                m_addr_rev = ref_bitrev(m_cnt);
                m_addr_nat = 5'(m_cnt);
                m_data     = d;
                m_cnt++;
            end
            if (full_now && (!m_busy || done)) begin
                m_bank   = !m_bank;
                m_start  = 1;
                m_busy   = 1;
                m_frames = m_frames + 16'd1;
                m_cnt    = 0;
            end else if (done) begin
                m_busy = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic both(input string tag, input logic [31:0] obs_r, input logic [31:0] obs_n,
                        input logic [31:0] exp);
        chk({"rev_", tag}, obs_r, exp);
        chk({"nat_", tag}, obs_n, exp);
    endtask

    initial begin
        rst = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        proc_done = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset held with s_valid high
        repeat (3) step(1'b1, 8'hA5, 1'b0, 1'b0);

        // Frame 1: data = index, continuous valid
        for (int i = 0; i < N_POINTS; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
        step(1'b1, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        both("f1_bank", 32'(if_rev.bank_sel), 32'(if_nat.bank_sel), 32'd1);
        both("f1_cnt", 32'(if_rev.frame_cnt), 32'(if_nat.frame_cnt), 32'd1);

        // Frame 2 with valid toggling, then backpressure while the core stays busy
        for (int i = 0; i < 2 * N_POINTS; i++)
            step((i % 2) == 0, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
        repeat (8) step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, 1'b1);
        both("bp_ready", 32'(if_rev.s_ready), 32'(if_nat.s_ready), 32'd0);
        both("bp_bank", 32'(if_rev.bank_sel), 32'(if_nat.bank_sel), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        both("bp_bank_back", 32'(if_rev.bank_sel), 32'(if_nat.bank_sel), 32'd0);

        // Frame 3: proc_done in the first FULL cycle
        for (int i = 0; i < N_POINTS; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        both("f3_cnt", 32'(if_rev.frame_cnt), 32'(if_nat.frame_cnt), 32'd3);

        // Frame 4 must wait: busy stayed set across the simultaneous done
        for (int i = 0; i < N_POINTS; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
        repeat (4) step(1'b1, 8'h00, 1'b0, 1'b1);
        both("f4_wait_cnt", 32'(if_rev.frame_cnt), 32'(if_nat.frame_cnt), 32'd3);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        // Frame 5: done clears busy, a spurious done follows, then an immediate swap
        for (int i = 0; i < N_POINTS; i++)
            step(1'b1, 8'($urandom_range(0, 255)), (i == 3) || (i == 7), 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
        both("f5_cnt", 32'(if_rev.frame_cnt), 32'(if_nat.frame_cnt), 32'd5);

        // Random traffic
        for (int i = 0; i < 160; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                 $urandom_range(0, 7) == 0, 1'b1);

        // Mid-frame reset
        repeat (2) step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
        repeat (2) step(1'b1, 8'h5A, 1'b0, 1'b0);
        both("rst_bank", 32'(if_rev.bank_sel), 32'(if_nat.bank_sel), 32'd0);
        both("rst_cnt", 32'(if_rev.frame_cnt), 32'(if_nat.frame_cnt), 32'd0);
        for (int i = 0; i < N_POINTS; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
        both("post_rst_bank", 32'(if_rev.bank_sel), 32'(if_nat.bank_sel), 32'd1);
        both("post_rst_cnt", 32'(if_rev.frame_cnt), 32'(if_nat.frame_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
